// File: rtl/rf_pkg.sv
// Shared defaults, derived widths and typedefs for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefNumRegs = 16;
  localparam int unsigned DefAddrW   = $clog2(DefNumRegs);
  localparam int unsigned DefCntW    = 2;

  typedef logic [DefAddrW-1:0] reg_idx_t;
  typedef logic [DefDataW-1:0] reg_data_t;
  typedef logic [DefCntW-1:0]  pend_cnt_t;

  // Largest value a pending-write counter of width cnt_w can hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Saturating pending-write counter for one architectural register.
module rf_pend_counter
  import rf_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             is_zero_o,
  output logic             is_max_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_eff, dec_eff;

  assign is_zero_o = (cnt_q == '0);
  assign is_max_o  = (cnt_q == CNT_W'(cnt_max(CNT_W)));
  // A writeback with nothing outstanding leaves the count alone and flags an error.
  assign dec_eff   = dec_i & ~is_zero_o;
  assign err_o     = dec_i & is_zero_o;
  assign inc_eff   = inc_i & (~is_max_o | dec_eff);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_eff && !dec_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc_eff && dec_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign cnt_next_o = cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters. Define RF_BYPASS_EN to forward
// same-cycle writeback data and busy release onto the read ports.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned CNT_W    = DefCntW,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned PEND_W  = ADDR_W + CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic              rd_busy1_o,
  output logic              rd_busy2_o,
  input  logic              rsv_valid_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              rsv_ready_o,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_err_o,
  output logic [PEND_W-1:0] pend_total_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec, is_zero, is_max, err;
  logic                rsv_acc;
  logic [PEND_W-1:0]   pend_total_q, pend_total_d;
  logic                wb_err_q, wb_err_d;
  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];
  logic                rd_busy [2];

  // A full counter can still accept when the same edge retires one write to it.
  assign rsv_ready_o = ~is_max[rsv_addr_i] | (wb_valid_i & (wb_addr_i == rsv_addr_i));
  assign rsv_acc     = rsv_valid_i & rsv_ready_o;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i] = rsv_acc & (rsv_addr_i == ADDR_W'(i));
    assign dec[i] = wb_valid_i & (wb_addr_i == ADDR_W'(i));

    rf_pend_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (inc[i]),
      .dec_i      (dec[i]),
      .cnt_next_o (cnt_next[i]),
      .is_zero_o  (is_zero[i]),
      .is_max_o   (is_max[i]),
      .err_o      (err[i])
    );
  end

  always_comb begin
    pend_total_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_total_d = pend_total_d + PEND_W'(cnt_next[i]);
    end
    wb_err_d = wb_err_q | (|err);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_total_q <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      pend_total_q <= pend_total_d;
      wb_err_q     <= wb_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid_i) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rd_addr[0] = rd_addr1_i;
  assign rd_addr[1] = rd_addr2_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = ~is_zero[rd_addr[p]];
`ifdef RF_BYPASS_EN
      if (wb_valid_i && (wb_addr_i == rd_addr[p])) begin
        rd_data[p] = wb_data_i;
        rd_busy[p] = ~is_zero[rd_addr[p]] & (cnt_next[rd_addr[p]] != '0);
      end
`endif
    end
  end

  assign rd_data1_o   = rd_data[0];
  assign rd_data2_o   = rd_data[1];
  assign rd_busy1_o   = rd_busy[0];
  assign rd_busy2_o   = rd_busy[1];
  assign wb_err_o     = wb_err_q;
  assign pend_total_o = pend_total_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array/counter model.
module tb_regfile_scoreboard;

  localparam int CntMax = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  rd_addr1_i, rd_addr2_i, rsv_addr_i, wb_addr_i;
  logic [15:0] rd_data1_o, rd_data2_o, wb_data_i;
  logic        rd_busy1_o, rd_busy2_o, rsv_valid_i, rsv_ready_o, wb_valid_i, wb_err_o;
  logic [5:0]  pend_total_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_mem [16];
  int          m_pend [16];
  bit          m_err;

  always #5 clk_i = ~clk_i;

  regfile_scoreboard u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_addr1_i   (rd_addr1_i),
    .rd_addr2_i   (rd_addr2_i),
    .rd_data1_o   (rd_data1_o),
    .rd_data2_o   (rd_data2_o),
    .rd_busy1_o   (rd_busy1_o),
    .rd_busy2_o   (rd_busy2_o),
    .rsv_valid_i  (rsv_valid_i),
    .rsv_addr_i   (rsv_addr_i),
    .rsv_ready_o  (rsv_ready_o),
    .wb_valid_i   (wb_valid_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .wb_err_o     (wb_err_o),
    .pend_total_o (pend_total_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int i = 0; i < 16; i++) s += m_pend[i];
    return s;
  endfunction

  function automatic void exp_read(input logic [3:0] a, input logic wv, input logic [3:0] wa,
                                   input logic [15:0] wd, input logic acc, input logic [3:0] ra,
                                   output logic [15:0] d, output logic b);
    d = m_mem[a];
    b = (m_pend[a] != 0);
`ifdef RF_BYPASS_EN
    if (wv && wa == a) begin
      d = wd;
      if (m_pend[a] == 1 && !(acc && ra == a)) b = 1'b0;
    end
`endif
  endfunction

  // Drive one cycle, check every output before the edge, then advance the model.
  task automatic step(input logic rv, input logic [3:0] ra, input logic wv,
                      input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] a1, input logic [3:0] a2);
    logic        rdy, acc, eb1, eb2;
    logic [15:0] ed1, ed2;
    rsv_valid_i = rv;  rsv_addr_i = ra;
    wb_valid_i  = wv;  wb_addr_i  = wa;  wb_data_i = wd;
    rd_addr1_i  = a1;  rd_addr2_i = a2;
    #2;
    rdy = (m_pend[ra] < CntMax) || (wv && wa == ra);
    acc = rv && rdy;
    exp_read(a1, wv, wa, wd, acc, ra, ed1, eb1);
    exp_read(a2, wv, wa, wd, acc, ra, ed2, eb2);
    chk("rd_data1", 32'(rd_data1_o), 32'(ed1));
    chk("rd_data2", 32'(rd_data2_o), 32'(ed2));
    chk("rd_busy1", 32'(rd_busy1_o), 32'(eb1));
    chk("rd_busy2", 32'(rd_busy2_o), 32'(eb2));
    chk("rsv_ready", 32'(rsv_ready_o), 32'(rdy));
    chk("wb_err", 32'(wb_err_o), 32'(m_err));
    chk("pend_total", 32'(pend_total_o), 32'(model_total()));
    @(posedge clk_i);
    if (wv) begin
      m_mem[wa] = wd;
      if (m_pend[wa] > 0) m_pend[wa]--;
      else m_err = 1'b1;
    end
    if (acc) m_pend[ra]++;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    rsv_valid_i = 1'b0; rsv_addr_i = '0; wb_valid_i = 1'b0; wb_addr_i = '0;
    wb_data_i = '0; rd_addr1_i = '0; rd_addr2_i = '0;
    model_reset();
    #2;
    chk("reset_pend_total", 32'(pend_total_o), 32'd0);
    chk("reset_wb_err", 32'(wb_err_o), 32'd0);
    chk("reset_rsv_ready", 32'(rsv_ready_o), 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));

    // Single reservation then writeback of r3.
    step(1, 3, 0, 0, 16'h0000, 3, 3);
    step(0, 0, 1, 3, 16'hBEEF, 3, 0);
    step(0, 0, 0, 0, 16'h0000, 3, 3);

    // WAW on r3.
    step(1, 3, 0, 0, 16'h0000, 3, 0);
    step(1, 3, 0, 0, 16'h0000, 3, 0);
    step(0, 0, 1, 3, 16'h1111, 3, 0);
    step(0, 0, 1, 3, 16'h2222, 3, 0);
    step(0, 0, 0, 0, 16'h0000, 3, 0);

    // Saturate r5, refused 4th, then 4th accepted alongside a writeback.
    step(1, 5, 0, 0, 16'h0000, 5, 0);
    step(1, 5, 0, 0, 16'h0000, 5, 0);
    step(1, 5, 0, 0, 16'h0000, 5, 0);
    step(1, 5, 0, 0, 16'h0000, 5, 0);
    step(1, 5, 1, 5, 16'h5555, 5, 0);
    step(0, 0, 0, 0, 16'h0000, 5, 0);

    // Writeback with nothing pending: error is sticky.
    step(0, 0, 1, 7, 16'h7777, 7, 5);
    step(0, 0, 0, 0, 16'h0000, 7, 5);
    step(0, 0, 0, 0, 16'h0000, 7, 5);

    // Bypass-sensitive case on r2.
    step(1, 2, 0, 0, 16'h0000, 2, 2);
    step(0, 0, 1, 2, 16'h1234, 2, 3);
    step(0, 0, 0, 0, 16'h0000, 2, 3);

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)), 16'($urandom),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    // Mid-operation async reset discards pending state; stale writeback then errs.
    step(1, 9, 0, 0, 16'h0000, 9, 9);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("midrst_pend_total", 32'(pend_total_o), 32'd0);
    chk("midrst_wb_err", 32'(wb_err_o), 32'd0);
    chk("midrst_busy1", 32'(rd_busy1_o), 32'd0);
    chk("midrst_data1", 32'(rd_data1_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    step(0, 0, 1, 9, 16'h9999, 9, 0);
    step(0, 0, 0, 0, 16'h0000, 9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 16x16 register file: DATA_W x NUM_REGS storage, two asynchronous read ports, one clocked writeback port.
- Per-register pending-write counter scoreboard replaces single in-use bits, so back-to-back writers of the same register (WAW) are tracked exactly.
- Sits between decode/operand-fetch (reads, reservations) and writeback in the 3-stage pipeline.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of architectural registers (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden)
- CNT_W, 2, pending-write counter width; max outstanding writes per register = 2^CNT_W-1

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- rd_addr1  in  ADDR_W  source register 1 index
- rd_addr2  in  ADDR_W  source register 2 index
- rd_data1  out  DATA_W  value of rd_addr1 (combinational)
- rd_data2  out  DATA_W  value of rd_addr2 (combinational)
- rd_busy1  out  1  rd_addr1 has pending writes
- rd_busy2  out  1  rd_addr2 has pending writes
- rsv_valid  in  1  decode requests reservation of rsv_addr
- rsv_addr  in  ADDR_W  destination register being reserved
- rsv_ready  out  1  reservation accepted this cycle (combinational)
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- wb_err  out  1  sticky: writeback seen to a register with zero pending count
- pend_total  out  ADDR_W+CNT_W  total outstanding reservations across all registers

Behaviour:
- Reset (rst low, async): all registers 0, all counters 0, wb_err 0, pend_total 0; rd_data* 0, rd_busy* 0, rsv_ready 1 while rsv_valid is low-independent (rsv_ready depends only on counter state).
- Read: rd_dataN = r[rd_addrN]; rd_busyN = (cnt[rd_addrN] != 0). Zero latency, no clock.
- Reservation: rsv_ready = (cnt[rsv_addr] != max) OR (wb_valid AND wb_addr == rsv_addr). Accepted when rsv_valid & rsv_ready; cnt increments at the clock edge.
- Writeback: on edge with wb_valid, r[wb_addr] <= wb_data; if cnt[wb_addr] != 0 it decrements, else cnt unchanged and wb_err <= 1 (data still written).
- Simultaneous accepted reservation and writeback, same register: cnt unchanged, data written, busy stays asserted.
- Simultaneous, different registers: one increment and one decrement, independent.
- pend_total = sum of all counters, registered, updated same edge (+1, -1, or net 0).
- Counter saturation: rsv_ready low; decode stalls; no counter wrap ever.
- Reset mid-operation: all pending state discarded; stale wb after reset sets wb_err.
- wb_err cleared only by reset.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: if wb_valid and wb_addr == rd_addrN, rd_dataN = wb_data same cycle; rd_busyN = 0 when cnt == 1 and the same cycle has no accepted reservation to that register.
- Undefined: reads see written value only after the edge; busy drops the cycle after writeback.

Decomposition:
- Package rf_pkg: DATA_W/NUM_REGS defaults, ADDR_W/CNT_W derivation, reg_idx_t, reg_data_t, pend_cnt_t typedefs.
- Sub-module rf_pend_counter: one saturating up/down counter (inc, dec, err flag, is_zero, is_max); instantiated NUM_REGS times via generate.

Test Plan:
- Reset then read r0..r15 -> all 0, busy 0, pend_total 0, wb_err 0.
- rsv r3, next cycle wb r3=0xBEEF -> busy3 1 for one cycle, then 0; rd_data 0xBEEF.
- WAW: rsv r3 twice, one wb -> busy3 still 1, pend_total 1; second wb -> busy3 0, pend_total 0.
- Reserve r5 3 times (CNT_W=2) -> rsv_ready 0 on 4th; 4th rsv with same-cycle wb r5 -> accepted, cnt stays 3.
- wb r7 with cnt 0 -> r7 written, wb_err 1 and stays 1 until rst low.
- RF_BYPASS_EN: cnt r2=1, wb r2=0x1234 while rd_addr1=2 -> rd_data1 0x1234, rd_busy1 0 same cycle; without macro -> old value and busy 1 that cycle.
